// File: rtl/floor_tracker.sv
// Cabin/motor side of the elevator drive: steps the cabin one floor per
// TRAVEL_CYCLES clocks under the en/up_down command, decides at each floor
// whether to keep going or stop, and runs a door dwell after every stop.
module floor_tracker #(
  parameter int FLOORS        = 16,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3,
  parameter int RESET_FLOOR   = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic       up_down,
  output logic [3:0] C,
  output logic       moving,
  output logic       dir,
  output logic       door_open,
  output logic       arrived,
  output logic       limit_err
);

  localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);
  localparam logic [3:0]    TOP_FLOOR   = 4'(FLOORS - 1);
  localparam logic [3:0]    HOME_FLOOR  = 4'(RESET_FLOOR);

  typedef enum logic [1:0] {
    IDLE,
    MOVING,
    CHECK,
    DOOR
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic [3:0]    c_next;
  logic          dir_next;
  logic          limit_next;
  logic          at_limit;

  // A move in the requested direction would leave the building.
  assign at_limit = up_down ? (C == TOP_FLOOR) : (C == 4'd0);

  // Next-state logic: the command is only looked at in IDLE and CHECK, never mid-floor.
  always_comb begin
    state_next = state;
    timer_next = timer;
    c_next     = C;
    dir_next   = dir;
    limit_next = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          if (at_limit) begin
            limit_next = 1'b1;
          end else begin
            state_next = MOVING;
            dir_next   = up_down;
            timer_next = '0;
          end
        end
      end
      MOVING: begin
        if (timer == TRAVEL_LAST) begin
          c_next     = dir ? (C + 4'd1) : (C - 4'd1);
          timer_next = '0;
          state_next = CHECK;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      CHECK: begin
        if (en && (up_down == dir) && !at_limit) begin
          state_next = MOVING;
          timer_next = '0;
        end else begin
          state_next = DOOR;
          timer_next = '0;
          limit_next = en && (up_down == dir);
        end
      end
      DOOR: begin
        if (timer == DOOR_LAST) begin
          state_next = IDLE;
          timer_next = '0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // State, floor and registered status outputs; reset re-homes the cabin even mid-trip.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      C         <= HOME_FLOOR;
      dir       <= 1'b0;
      moving    <= 1'b0;
      door_open <= 1'b0;
      arrived   <= 1'b0;
      limit_err <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      C         <= c_next;
      dir       <= dir_next;
      moving    <= (state_next == MOVING);
      door_open <= (state_next == DOOR);
      arrived   <= (state == CHECK) && (state_next == DOOR);
      limit_err <= limit_next;
    end
  end

endmodule

// File: tb/tb_floor_tracker.sv
// Self-checking bench for floor_tracker: directed elevator scenarios followed
// by randomized commands, all compared cycle by cycle against a countdown model.
module tb_floor_tracker;

  localparam int FLOORS = 16;
  localparam int TRAVEL = 4;
  localparam int DWELL  = 3;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       en;
  logic       up_down;
  logic [3:0] C;
  logic       moving;
  logic       dir;
  logic       door_open;
  logic       arrived;
  logic       limit_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: floor number plus countdowns for remaining travel and dwell.
  int m_floor;
  bit m_dir;
  int m_travel_left;
  int m_door_left;
  bit m_decide;
  bit e_moving;
  bit e_door;
  bit e_arrived;
  bit e_limit;

  int target;
  bit closed_loop;

  floor_tracker #(
    .FLOORS(FLOORS),
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES(DWELL),
    .RESET_FLOOR(0)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .en(en),
    .up_down(up_down),
    .C(C),
    .moving(moving),
    .dir(dir),
    .door_open(door_open),
    .arrived(arrived),
    .limit_err(limit_err)
  );

  // Free-running system clock.
  always #5 clock = ~clock;

  function automatic bit blocked(input bit ud);
    return ud ? (m_floor == FLOORS - 1) : (m_floor == 0);
  endfunction

  task automatic modelEdge(input bit rst_n, input bit e, input bit ud);
    e_arrived = 1'b0;
    e_limit   = 1'b0;
    if (!rst_n) begin
      m_floor       = 0;
      m_dir         = 1'b0;
      m_travel_left = 0;
      m_door_left   = 0;
      m_decide      = 1'b0;
    end else if (m_travel_left > 0) begin
      m_travel_left--;
      if (m_travel_left == 0) begin
        m_floor  = m_dir ? m_floor + 1 : m_floor - 1;
        m_decide = 1'b1;
      end
    end else if (m_decide) begin
      m_decide = 1'b0;
      if (e && ud == m_dir && !blocked(ud)) begin
        m_travel_left = TRAVEL;
      end else begin
        m_door_left = DWELL;
        e_arrived   = 1'b1;
        e_limit     = e && (ud == m_dir);
      end
    end else if (m_door_left > 0) begin
      m_door_left--;
    end else if (e) begin
      if (blocked(ud)) begin
        e_limit = 1'b1;
      end else begin
        m_dir         = ud;
        m_travel_left = TRAVEL;
      end
    end
    e_moving = (m_travel_left > 0);
    e_door   = (m_door_left > 0);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", tag, observed, expected, $time);
  endtask

  task automatic checkAll();
    checkOutput("floor", C, 4'(m_floor));
    checkOutput("moving", {3'b0, moving}, {3'b0, e_moving});
    checkOutput("dir", {3'b0, dir}, {3'b0, m_dir});
    checkOutput("door_open", {3'b0, door_open}, {3'b0, e_door});
    checkOutput("arrived", {3'b0, arrived}, {3'b0, e_arrived});
    checkOutput("limit_err", {3'b0, limit_err}, {3'b0, e_limit});
  endtask

  // One clock: derive the command from the target when the loop is closed, then compare.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (closed_loop) begin
        en      = (target != m_floor);
        up_down = (target > m_floor);
      end
      @(posedge clock);
      modelEdge(reset_n, en, up_down);
      #1;
      checkAll();
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    en          = 1'b0;
    up_down     = 1'b0;
    closed_loop = 1'b0;
    target      = 0;

    // Reset for two cycles, then idle with no command.
    applyStimulus(2);
    checkOutput("reset_floor", C, 4'd0);
    reset_n = 1'b1;
    applyStimulus(3);
    checkOutput("idle_still", {3'b0, moving}, 4'd0);

    // Two-floor trip up with a continue at the intermediate floor.
    closed_loop = 1'b1;
    target      = 2;
    applyStimulus(5);
    checkOutput("t2_edge5_floor", C, 4'd1);
    applyStimulus(5);
    checkOutput("t2_edge10_floor", C, 4'd2);
    applyStimulus(1);
    checkOutput("t2_edge11_arrived", {3'b0, arrived}, 4'd1);
    applyStimulus(2);
    checkOutput("t2_edge13_door", {3'b0, door_open}, 4'd1);
    applyStimulus(1);
    checkOutput("t2_edge14_door", {3'b0, door_open}, 4'd0);

    // Return to the ground floor, then request a move below it.
    target = 0;
    applyStimulus(20);
    closed_loop = 1'b0;
    en          = 1'b1;
    up_down     = 1'b0;
    applyStimulus(1);
    checkOutput("t3_limit", {3'b0, limit_err}, 4'd1);
    en = 1'b0;
    applyStimulus(1);
    checkOutput("t3_limit_clear", {3'b0, limit_err}, 4'd0);
    checkOutput("t3_floor", C, 4'd0);

    // Reversal requested while travelling 0->1: stop at 1, dwell, then head back down.
    closed_loop = 1'b1;
    target      = 3;
    applyStimulus(2);
    target = 0;
    applyStimulus(20);
    checkOutput("t4_floor", C, 4'd0);
    checkOutput("t4_dir", {3'b0, dir}, 4'd0);

    // Reset in the middle of a floor of travel.
    target = 5;
    applyStimulus(3);
    reset_n = 1'b0;
    applyStimulus(1);
    checkOutput("t5_floor", C, 4'd0);
    checkOutput("t5_moving", {3'b0, moving}, 4'd0);
    reset_n = 1'b1;
    target  = 0;
    applyStimulus(2);

    // Command noise while moving does not disturb the floor step.
    target = 4;
    applyStimulus(1);
    closed_loop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en      = 1'($urandom);
      up_down = 1'($urandom);
      applyStimulus(1);
    end
    closed_loop = 1'b1;
    applyStimulus(30);
    checkOutput("t6_floor", C, 4'd4);

    // Constant up command runs the cabin into the top floor via CHECK, then IDLE.
    closed_loop = 1'b0;
    en          = 1'b1;
    up_down     = 1'b1;
    applyStimulus(70);
    checkOutput("top_floor", C, 4'd15);
    applyStimulus(6);
    en = 1'b0;
    applyStimulus(2);

    // Randomized targets, open-loop command bursts and occasional resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) target = int'($urandom_range(0, FLOORS - 1));
      closed_loop = ($urandom_range(0, 7) != 0);
      if (!closed_loop) begin
        en      = 1'($urandom);
        up_down = 1'($urandom);
      end
      reset_n = ($urandom_range(0, 149) != 0);
      applyStimulus(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
